maze_solver: RTL and testbench



---
 rtl/maze_pkg.sv | 56 +++++
 rtl/maze_solver_if.sv | 24 ++
 rtl/maze_move_stack.sv | 36 +++
 rtl/maze_solver.sv | 119 +++++++++++
 tb/tb_maze_solver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared types, geometry constants and step helpers for the maze DFS solver.
package maze_pkg;
  localparam int unsigned COORD_W     = 4;
  localparam int unsigned STACK_DEPTH = 256;
  localparam int unsigned SP_W        = 9;

  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {RIGHT = 2'd0, DOWN = 2'd1, LEFT = 2'd2, UP = 2'd3} dir_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHK_START = 3'd1;
  localparam state_t ST_MARK      = 3'd2;
  localparam state_t ST_PROBE     = 3'd3;
  localparam state_t ST_BACKTRACK = 3'd4;
  localparam state_t ST_REPLAY    = 3'd5;
  localparam state_t ST_DONE      = 3'd6;
  localparam state_t ST_FAIL      = 3'd7;

  localparam coord_t START_X = '0;
  localparam coord_t START_Y = '0;
  localparam coord_t GOAL_X  = '1;
  localparam coord_t GOAL_Y  = '1;

  function automatic pos_t step(pos_t p, dir_t d);
    pos_t n;
    n = p;
    case (d)
      RIGHT:   n.y = p.y + 1'b1;
      DOWN:    n.x = p.x + 1'b1;
      LEFT:    n.y = p.y - 1'b1;
      default: n.x = p.x - 1'b1;
    endcase
    return n;
  endfunction

  // True when stepping from p in direction d stays inside the maze.
  function automatic logic in_bounds(pos_t p, dir_t d);
    case (d)
      RIGHT:   return p.y != '1;
      DOWN:    return p.x != '1;
      LEFT:    return p.y != '0;
      default: return p.x != '0;
    endcase
  endfunction

  function automatic dir_t opposite(dir_t d);
    logic [1:0] v;
    v = d + 2'd2;
    return dir_t'(v);
  endfunction
endpackage

// File: rtl/maze_solver_if.sv
// Maze-memory bit port plus the move stream, bundled between solver and its peers.
interface maze_solver_if;
  import maze_pkg::*;

  logic       mem_rd;
  logic       mem_wr;
  logic       mem_din;
  coord_t     mem_x;
  coord_t     mem_y;
  logic       mem_dout;
  logic [1:0] move;
  logic       move_valid;
  logic       move_ready;

  modport master (
    output mem_rd, mem_wr, mem_din, mem_x, mem_y, move, move_valid,
    input  mem_dout, move_ready
  );

  modport slave (
    input  mem_rd, mem_wr, mem_din, mem_x, mem_y, move, move_valid,
    output mem_dout, move_ready
  );
endinterface

// File: rtl/maze_move_stack.sv
// LIFO of path moves; also readable by index so the path replays start-to-goal.
module maze_move_stack
  import maze_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push,
  input  dir_t            push_dir,
  input  logic            pop,
  output dir_t            top,
  input  logic [SP_W-1:0] rd_idx,
  output dir_t            rd_data,
  output logic [SP_W-1:0] sp,
  output logic            empty
);
  dir_t            mem [STACK_DEPTH];
  logic [SP_W-2:0] top_idx;

  always_ff @(posedge clk) begin
    if (push) mem[sp[SP_W-2:0]] <= push_dir;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) sp <= '0;
    else if (push)       sp <= sp + 1'b1;
    else if (pop)        sp <= sp - 1'b1;
  end

  always_comb begin
    top_idx = sp[SP_W-2:0] - 1'b1;
    top     = mem[top_idx];
    rd_data = mem[rd_idx[SP_W-2:0]];
    empty   = (sp == '0);
  end
endmodule

// File: rtl/maze_solver.sv
// Depth-first maze solver: marks cells in the external bit memory, then replays the path.
module maze_solver
  import maze_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic fail,
  maze_solver_if.master bus
);
  state_t          state;
  pos_t            cur;
  logic [2:0]      dir;
  logic [SP_W-1:0] rd_idx;

  dir_t            pdir;
  pos_t            nbr;
  logic            nbr_ok;
  logic            start_ok;
  logic            push;
  logic            pop;
  dir_t            top;
  dir_t            rd_data;
  logic [SP_W-1:0] sp;
  logic            empty;

  // dir[2] marks the exhausted state: all four directions tried.
  always_comb begin
    pdir     = dir_t'(dir[1:0]);
    nbr      = step(cur, pdir);
    nbr_ok   = !dir[2] && in_bounds(cur, pdir);
    start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
    push     = (state == ST_PROBE) && nbr_ok && !bus.mem_dout;
    pop      = (state == ST_BACKTRACK) && !empty;
  end

  maze_move_stack u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .push     (push),
    .push_dir (pdir),
    .pop      (pop),
    .top      (top),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .sp       (sp),
    .empty    (empty)
  );

  always_comb begin
    bus.mem_rd     = (state == ST_CHK_START) || ((state == ST_PROBE) && nbr_ok);
    bus.mem_wr     = (state == ST_MARK);
    bus.mem_din    = (state == ST_MARK);
    bus.mem_x      = (state == ST_PROBE) ? nbr.x : cur.x;
    bus.mem_y      = (state == ST_PROBE) ? nbr.y : cur.y;
    bus.move_valid = (state == ST_REPLAY);
    bus.move       = (state == ST_REPLAY) ? rd_data : 2'b00;
    busy           = !(state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
    done           = (state == ST_DONE);
    fail           = (state == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur    <= '0;
      dir    <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        ST_CHK_START: state <= bus.mem_dout ? ST_FAIL : ST_MARK;
        ST_MARK: begin
          dir <= '0;
          if (cur.x == GOAL_X && cur.y == GOAL_Y) begin
            rd_idx <= '0;
            state  <= ST_REPLAY;
          end else begin
            state <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (dir[2]) begin
            state <= ST_BACKTRACK;
          end else if (push) begin
            cur   <= nbr;
            state <= ST_MARK;
          end else begin
            dir <= dir + 3'd1;
          end
        end
        ST_BACKTRACK: begin
          if (empty) begin
            state <= ST_FAIL;
          end else begin
            cur   <= step(cur, opposite(top));
            dir   <= {1'b0, top} + 3'd1;
            state <= ST_PROBE;
          end
        end
        ST_REPLAY: begin
          if (bus.move_ready) begin
            if (rd_idx == sp - 1'b1) state <= ST_DONE;
            else                     rd_idx <= rd_idx + 1'b1;
          end
        end
        default: begin
          if (start_ok) begin
            cur   <= '{x: START_X, y: START_Y};
            dir   <= '0;
            state <= ST_CHK_START;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver: bit-memory model, table of maze scenarios, reset-in-probe case.
module tb_maze_solver;
  import maze_pkg::*;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic fail;

  maze_solver_if bus ();

  maze_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .fail  (fail),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic maze_m [16][16];
  int   wr_count;
  int   rdwr_clash;
  int   total;
  int   bad;

  assign bus.mem_dout = bus.mem_rd ? maze_m[bus.mem_x][bus.mem_y] : 1'b0;

  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_wr) rdwr_clash = rdwr_clash + 1;
    if (bus.mem_wr) begin
      maze_m[bus.mem_x][bus.mem_y] = bus.mem_din;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    int         kind;      // 0 open, 1 start walled, 2 dead end, 3 goal enclosed
    bit         exp_done;
    int         len_a;
    logic [1:0] dir_a;
    int         len_b;
    logic [1:0] dir_b;
    int         stall_at;  // move index held back for 5 cycles, -1 for none
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic maze_init(int kind, int i, int j);
    case (kind)
      1:       return (i == 0 && j == 0);
      2:       return !((i == 0 && j == 1) || j == 0 || i == 15);
      3:       return (i == 14 && j == 15) || (i == 15 && j == 14);
      default: return 1'b0;
    endcase
  endfunction

  // Expected memory contents after the solver finishes.
  function automatic logic maze_final(int kind, int i, int j);
    case (kind)
      0, 4:    return (i == 0 || j == 15);
      1:       return (i == 0 && j == 0);
      2:       return 1'b1;
      default: return !(i == 15 && j == 15);
    endcase
  endfunction

  task automatic load_maze(input int kind);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        maze_m[i][j] = maze_init(kind, i, j);
    wr_count = 0;
  endtask

  task automatic run_case(input vec_t v, input string tag);
    logic [1:0] got[$];
    logic [1:0] exp_mv;
    bit         finished;
    int         fin_c;
    int         stall_cnt;
    int         mem_bad;
    got.delete();
    load_maze(v.kind);
    finished  = 1'b0;
    fin_c     = -1;
    stall_cnt = 0;
    bus.move_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      if (done || fail) begin
        finished = 1'b1;
        fin_c    = c;
      end else if (bus.move_valid) begin
        if (got.size() == v.stall_at && stall_cnt < 5) begin
          exp_mv = (v.stall_at < v.len_a) ? v.dir_a : v.dir_b;
          check({tag, " stall_hold"}, {31'd0, bus.move_valid} * 4 + int'(bus.move),
                4 + int'(exp_mv));
          bus.move_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.move_ready = 1'b1;
          got.push_back(bus.move);
        end
        @(negedge clk);
      end else begin
        bus.move_ready = 1'b0;
        @(negedge clk);
      end
    end
    bus.move_ready = 1'b0;
    check({tag, " finished"}, int'(finished), 1);
    check({tag, " done"}, int'(done), int'(v.exp_done));
    check({tag, " fail"}, int'(fail), int'(!v.exp_done));
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " move_count"}, got.size(), v.len_a + v.len_b);
    for (int i = 0; i < got.size() && i < v.len_a + v.len_b; i++) begin
      exp_mv = (i < v.len_a) ? v.dir_a : v.dir_b;
      check($sformatf("%s move[%0d]", tag, i), int'(got[i]), int'(exp_mv));
    end
    if (v.stall_at >= 0) check({tag, " stall_cycles"}, stall_cnt, 5);
    if (v.kind == 1) begin
      check({tag, " fail_latency_ok"}, int'(fin_c >= 0 && fin_c <= 3), 1);
      check({tag, " no_write"}, wr_count, 0);
    end
    if (v.kind == 2) check({tag, " cell01_marked"}, int'(maze_m[0][1]), 1);
    mem_bad = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (maze_m[i][j] !== maze_final(v.kind, i, j)) mem_bad++;
    check({tag, " mem_marks"}, mem_bad, 0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    wr_count   = 0;
    rdwr_clash = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    bus.move_ready = 1'b0;
    load_maze(0);

    vecs[0] = '{kind: 0, exp_done: 1'b1, len_a: 15, dir_a: 2'd0, len_b: 15, dir_b: 2'd1,
                stall_at: -1};
    vecs[1] = '{kind: 1, exp_done: 1'b0, len_a: 0,  dir_a: 2'd0, len_b: 0,  dir_b: 2'd0,
                stall_at: -1};
    vecs[2] = '{kind: 2, exp_done: 1'b1, len_a: 15, dir_a: 2'd1, len_b: 15, dir_b: 2'd0,
                stall_at: -1};
    vecs[3] = '{kind: 3, exp_done: 1'b0, len_a: 0,  dir_a: 2'd0, len_b: 0,  dir_b: 2'd0,
                stall_at: -1};
    vecs[4] = '{kind: 4, exp_done: 1'b1, len_a: 15, dir_a: 2'd0, len_b: 15, dir_b: 2'd1,
                stall_at: 6};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({busy, done, fail, bus.mem_rd, bus.mem_wr, bus.mem_din,
                                 bus.mem_x, bus.mem_y, bus.move, bus.move_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_case(vecs[k], $sformatf("vec%0d", k));

    // Reset while the first neighbour probe is in flight.
    load_maze(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("probe_rd", int'(bus.mem_rd), 1);
    check("probe_addr", int'({bus.mem_x, bus.mem_y}), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", int'({busy, done, fail, bus.mem_rd, bus.mem_wr, bus.mem_din,
                                     bus.mem_x, bus.mem_y, bus.move, bus.move_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case(vecs[0], "rerun");

    check("rd_wr_exclusive", rdwr_clash, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
